lru_order_queue: RTL and testbench

Parametrised recency-ordered slot queue: a doubly linked list over `DEPTH = 2**IDX_WIDTH` slots. The head is the next victim and the tail is the most recently used slot. It serves as the eviction-order keeper for the cache and flow-table blocks. It adds four things the previous queue lacked: valid/ready handshakes, per-slot valid bits with occupancy, explicit retire (move to head) and write-in-place, and error responses instead of a sticky crash. Slot data is held locally and returned on eviction.

---
 rtl/lru_order_queue_pkg.sv | 26 ++
 rtl/lru_order_queue.sv | 171 +++++++++++++++++
 tb/tb_lru_order_queue.sv | 267 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/lru_order_queue_pkg.sv
// Shared definitions for the recency-ordered slot queue: command codes, FSM states
// and small command-classification helpers.
package lru_order_queue_pkg;

  typedef enum logic [2:0] {
    CMD_NOP    = 3'd0,
    CMD_ENLIST = 3'd1,
    CMD_TOUCH  = 3'd2,
    CMD_READ   = 3'd3,
    CMD_WRITE  = 3'd4,
    CMD_RETIRE = 3'd5
  } cmd_e;

  localparam logic [0:0] ST_INIT = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  // Commands that are only legal on a slot that currently holds valid data.
  function automatic logic needs_valid(input logic [2:0] c);
    return (c == CMD_TOUCH) || (c == CMD_WRITE) || (c == CMD_RETIRE);
  endfunction

  function automatic logic moves_to_tail(input logic [2:0] c);
    return (c == CMD_ENLIST) || (c == CMD_TOUCH);
  endfunction

endpackage

// File: rtl/lru_order_queue.sv
// Recency-ordered slot queue: doubly linked list over DEPTH slots, head = next victim,
// tail = most recently used. Valid/ready commands, registered back-pressured response.
//
// state   | meaning
// ST_INIT | building the list, one slot per cycle, head=0 .. tail=DEPTH-1
// ST_RUN  | accepting commands until the next reset
module lru_order_queue
  import lru_order_queue_pkg::*;
#(
  parameter int IDX_WIDTH  = 3,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [2:0]            cmd,
  input  logic [IDX_WIDTH-1:0]  idx_in,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic                  rsp_err,
  output logic                  rsp_flag,
  output logic [IDX_WIDTH-1:0]  idx_out,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic [IDX_WIDTH:0]    count,
  output logic                  init_done
);

  localparam int DEPTH = 2 ** IDX_WIDTH;

  logic [0:0]            state;
  logic [IDX_WIDTH-1:0]  init_ptr;
  logic [IDX_WIDTH-1:0]  head;
  logic [IDX_WIDTH-1:0]  tail;

  logic [IDX_WIDTH-1:0]  prev_mem [DEPTH];
  logic [IDX_WIDTH-1:0]  next_mem [DEPTH];
  logic [DATA_WIDTH-1:0] data_mem [DEPTH];
  logic [DEPTH-1:0]      valid_mem;

  logic                  accept;
  logic [IDX_WIDTH-1:0]  tgt;
  logic [IDX_WIDTH-1:0]  tgt_prev;
  logic [IDX_WIDTH-1:0]  tgt_next;
  logic [DATA_WIDTH-1:0] tgt_data;
  logic                  tgt_valid;
  logic                  cmd_err;
  logic [IDX_WIDTH-1:0]  rsp_idx_d;
  logic [DATA_WIDTH-1:0] rsp_data_d;
  logic                  rsp_flag_d;
  logic                  ok;
  logic                  do_tail;
  logic                  do_head;
  logic                  wr_data;
  logic                  clr_valid;

  assign init_done = (state == ST_RUN);
  assign cmd_ready = init_done && (!rsp_valid || rsp_ready);
  assign accept    = cmd_valid && cmd_ready;

  assign tgt       = (cmd == CMD_ENLIST) ? head : idx_in;
  assign tgt_prev  = prev_mem[tgt];
  assign tgt_next  = next_mem[tgt];
  assign tgt_data  = data_mem[tgt];
  assign tgt_valid = valid_mem[tgt];

  always_comb begin
    rsp_idx_d  = idx_in;
    rsp_data_d = tgt_data;
    rsp_flag_d = 1'b0;
    cmd_err    = 1'b0;
    case (cmd)
      CMD_NOP: begin
        rsp_idx_d  = '0;
        rsp_data_d = '0;
      end
      CMD_ENLIST: begin
        rsp_idx_d  = head;
        rsp_flag_d = tgt_valid;
      end
      CMD_READ:                     rsp_flag_d = tgt_valid;
      CMD_TOUCH, CMD_WRITE, CMD_RETIRE: cmd_err = needs_valid(cmd) && !tgt_valid;
      default:                      cmd_err = 1'b1;
    endcase
    if (cmd_err) begin
      rsp_data_d = '0;
      rsp_flag_d = 1'b0;
    end
  end

  assign ok        = accept && !cmd_err;
  assign do_tail   = ok && moves_to_tail(cmd) && (tgt != tail);
  assign do_head   = ok && (cmd == CMD_RETIRE) && (tgt != head);
  assign wr_data   = ok && ((cmd == CMD_ENLIST) || (cmd == CMD_WRITE));
  assign clr_valid = ok && (cmd == CMD_RETIRE);

  // List memory is rebuilt by INIT after every reset, so it carries no reset itself.
  always_ff @(posedge clock) begin
    if (state == ST_INIT) begin
      prev_mem[init_ptr]  <= init_ptr - IDX_WIDTH'(1);
      next_mem[init_ptr]  <= init_ptr + IDX_WIDTH'(1);
      valid_mem[init_ptr] <= 1'b0;
      data_mem[init_ptr]  <= '0;
    end else begin
      if (do_tail) begin
        if (tgt != head) next_mem[tgt_prev] <= tgt_next;
        prev_mem[tgt_next] <= tgt_prev;
        next_mem[tail]     <= tgt;
        prev_mem[tgt]      <= tail;
      end
      if (do_head) begin
        if (tgt != tail) prev_mem[tgt_next] <= tgt_prev;
        next_mem[tgt_prev] <= tgt_next;
        prev_mem[head]     <= tgt;
        next_mem[tgt]      <= head;
      end
      if (wr_data) data_mem[tgt] <= data_in;
      if (accept && (cmd == CMD_ENLIST)) valid_mem[tgt] <= 1'b1;
      if (clr_valid) valid_mem[tgt] <= 1'b0;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state     <= ST_INIT;
      init_ptr  <= '0;
      head      <= '0;
      tail      <= '0;
      count     <= '0;
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_flag  <= 1'b0;
      idx_out   <= '0;
      data_out  <= '0;
    end else begin
      case (state)
        ST_INIT: begin
          init_ptr <= init_ptr + IDX_WIDTH'(1);
          if (init_ptr == IDX_WIDTH'(DEPTH - 1)) begin
            state <= ST_RUN;
            head  <= '0;
            tail  <= IDX_WIDTH'(DEPTH - 1);
          end
        end
        default: begin
          if (accept) begin
            rsp_valid <= 1'b1;
            rsp_err   <= cmd_err;
            rsp_flag  <= rsp_flag_d;
            idx_out   <= rsp_idx_d;
            data_out  <= rsp_data_d;
            if (do_tail) begin
              if (tgt == head) head <= tgt_next;
              tail <= tgt;
            end
            if (do_head) begin
              if (tgt == tail) tail <= tgt_prev;
              head <= tgt;
            end
            if ((cmd == CMD_ENLIST) && !tgt_valid) count <= count + (IDX_WIDTH+1)'(1);
            else if (clr_valid)                     count <= count - (IDX_WIDTH+1)'(1);
          end else if (rsp_ready) begin
            rsp_valid <= 1'b0;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lru_order_queue.sv
// Scoreboard bench for lru_order_queue: an ordered-list reference model predicts each
// response at acceptance; responses are popped and compared when consumed.
module tb_lru_order_queue;
  localparam int IW    = 3;
  localparam int DW    = 8;
  localparam int DEPTH = 8;

  logic          clock     = 1'b0;
  logic          reset_n   = 1'b0;
  logic          cmd_valid = 1'b0;
  logic          rsp_ready = 1'b1;
  logic [2:0]    cmd       = '0;
  logic [IW-1:0] idx_in    = '0;
  logic [DW-1:0] data_in   = '0;
  logic          cmd_ready, rsp_valid, rsp_err, rsp_flag, init_done;
  logic [IW-1:0] idx_out;
  logic [DW-1:0] data_out;
  logic [IW:0]   count;

  typedef struct packed {
    logic          err;
    logic          flag;
    logic [IW-1:0] idx;
    logic [DW-1:0] data;
    logic [IW:0]   cnt;
  } exp_t;

  exp_t          exp_q[$];
  int            checks   = 0;
  int            failures = 0;
  int            order[$];
  logic [DEPTH-1:0] mv;
  logic [DW-1:0] md [DEPTH];
  int            mcount;

  lru_order_queue #(.IDX_WIDTH(IW), .DATA_WIDTH(DW)) dut (
    .clock(clock), .reset_n(reset_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd(cmd), .idx_in(idx_in), .data_in(data_in), .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready), .rsp_err(rsp_err), .rsp_flag(rsp_flag), .idx_out(idx_out),
    .data_out(data_out), .count(count), .init_done(init_done)
  );

  always #5 clock = ~clock;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, want, $time);
    end
  endtask

  task automatic model_reset();
    order.delete();
    for (int k = 0; k < DEPTH; k++) begin
      order.push_back(k);
      md[k] = '0;
    end
    mv     = '0;
    mcount = 0;
  endtask

  task automatic model_remove(input int s);
    for (int k = 0; k < order.size(); k++)
      if (order[k] == s) begin
        order.delete(k);
        break;
      end
  endtask

  task automatic model_apply(input logic [2:0] c, input logic [IW-1:0] i,
                             input logic [DW-1:0] d, output exp_t e);
    int h;
    e     = '0;
    e.idx = i;
    case (c)
      3'd0: e.idx = '0;
      3'd1: begin
        h      = order.pop_front();
        e.idx  = IW'(h);
        e.data = md[h];
        e.flag = mv[h];
        if (!mv[h]) mcount++;
        md[h] = d;
        mv[h] = 1'b1;
        order.push_back(h);
      end
      3'd2, 3'd4, 3'd5: begin
        if (!mv[i]) e.err = 1'b1;
        else begin
          e.data = md[i];
          if (c == 3'd2) begin
            model_remove(int'(i));
            order.push_back(int'(i));
          end else if (c == 3'd4) begin
            md[i] = d;
          end else begin
            mv[i] = 1'b0;
            mcount--;
            model_remove(int'(i));
            order.push_front(int'(i));
          end
        end
      end
      3'd3: begin
        e.data = md[i];
        e.flag = mv[i];
      end
      default: e.err = 1'b1;
    endcase
    e.cnt = (IW+1)'(mcount);
  endtask

  // A response shown with rsp_ready high at a falling edge is consumed at the next rising edge.
  always @(negedge clock) begin : monitor
    exp_t e;
    if (reset_n && rsp_valid && rsp_ready) begin
      if (exp_q.size() == 0) check_val("rsp_unexpected", exp_q.size(), 1);
      else begin
        e = exp_q.pop_front();
        check_val("rsp_err", rsp_err, e.err);
        check_val("rsp_flag", rsp_flag, e.flag);
        check_val("idx_out", idx_out, e.idx);
        check_val("data_out", data_out, e.data);
        check_val("count", count, e.cnt);
      end
    end
  end

  task automatic send(input logic [2:0] c, input logic [IW-1:0] i, input logic [DW-1:0] d);
    exp_t e;
    int   waited = 0;
    cmd       = c;
    idx_in    = i;
    data_in   = d;
    cmd_valid = 1'b1;
    while (1) begin
      @(negedge clock);
      if (cmd_ready) break;
      waited++;
      if (waited > 50) begin
        check_val("cmd_ready_timeout", cmd_ready, 1);
        cmd_valid = 1'b0;
        return;
      end
    end
    model_apply(c, i, d, e);
    exp_q.push_back(e);
    @(posedge clock);
    #1;
    cmd_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic check_zero(input string tag);
    check_val(tag, {cmd_ready, rsp_valid, rsp_err, rsp_flag, idx_out, data_out, count, init_done}, 0);
  endtask

  task automatic wait_init();
    for (int k = 1; k <= DEPTH; k++) begin
      @(posedge clock);
      #1;
      check_val("init_done", init_done, (k == DEPTH));
      check_val("cmd_ready_init", cmd_ready, (k == DEPTH));
    end
  endtask

  task automatic hard_reset();
    idle(2);
    check_val("drain", exp_q.size(), 0);
    reset_n = 1'b0;
    #2;
    check_zero("reset_outputs");
    exp_q.delete();
    model_reset();
    @(posedge clock);
    #1;
    reset_n = 1'b1;
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    #2;
    check_zero("por_outputs");
    @(posedge clock);
    #1;
    reset_n = 1'b1;
    wait_init();
    send(3'd1, 0, 8'hA1);

    hard_reset();
    wait_init();
    for (int k = 0; k < 9; k++) send(3'd1, 0, DW'(8'h10 + k));

    hard_reset();
    wait_init();
    for (int k = 0; k < 8; k++) send(3'd1, 0, DW'(8'h10 + k));
    send(3'd2, 0, 0);
    send(3'd1, 0, 8'h55);
    send(3'd2, 1, 0);
    send(3'd1, 0, 8'h77);

    send(3'd5, 5, 0);
    send(3'd1, 0, 8'h66);
    send(3'd5, 5, 0);
    send(3'd5, 5, 0);
    send(3'd3, 5, 0);
    send(3'd4, 5, 8'hEE);
    send(3'd2, 5, 0);
    send(3'd4, 3, 8'h99);
    send(3'd3, 3, 0);
    send(3'd0, 6, 8'hFF);
    send(3'd7, 2, 0);
    send(3'd6, 4, 0);

    send(3'd3, 3, 0);
    rsp_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clock);
      check_val("hold_valid", rsp_valid, 1);
      check_val("hold_cmd_ready", cmd_ready, 0);
      check_val("hold_idx", idx_out, exp_q[0].idx);
      check_val("hold_data", data_out, exp_q[0].data);
      check_val("hold_flag", rsp_flag, exp_q[0].flag);
    end
    @(posedge clock);
    #1;
    rsp_ready = 1'b1;

    for (int n = 0; n < 300; n++) begin
      logic [2:0] c;
      c = ($urandom_range(0, 3) == 0) ? 3'd1 : 3'($urandom_range(0, 7));
      send(c, IW'($urandom_range(0, DEPTH - 1)), DW'($urandom_range(0, 255)));
    end

    hard_reset();
    for (int k = 0; k < 4; k++) begin
      @(posedge clock);
      #1;
      check_val("mid_init_done", init_done, 0);
    end
    reset_n = 1'b0;
    #2;
    check_zero("mid_init_reset");
    @(posedge clock);
    #1;
    reset_n = 1'b1;
    wait_init();
    send(3'd1, 0, 8'h3C);

    idle(3);
    check_val("final_drain", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
